imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter MAX_WORDS, default 64, meaning the largest program length in 32-bit words that SHALL be accepted.
REQ-002 Parameter BASE_ADDR, default 32'h0000_0000, meaning the byte address of the first written instruction word.
REQ-003 clk  input  1  single clock; all state SHALL change on the rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 start  input  1  single-cycle request to begin a load.
REQ-006 byte_in  input  8  serial program byte.
REQ-007 byte_valid  input  1  byte_in is valid this cycle.
REQ-008 byte_ready  output  1  loader accepts byte_in this cycle.
REQ-009 mem_we  output  1  instruction-memory write strobe.
REQ-010 mem_addr  output  32  instruction-memory byte address.
REQ-011 mem_wdata  output  32  instruction word to write.
REQ-012 cpu_hold  output  1  holds the processor PC and register writes while high.
REQ-013 done  output  1  load completed successfully.
REQ-014 error  output  1  load rejected, with the length exceeding MAX_WORDS.
REQ-015 word_count  output  16  number of words written in the current load.

Function
REQ-016 States SHALL be IDLE, HDR0, HDR1, DATA, WRITE, DONE and ERR.
REQ-017 A byte SHALL be accepted only on a rising edge where byte_valid and byte_ready are both 1.
REQ-018 byte_ready SHALL be 1 only in HDR0, HDR1 and DATA, and SHALL be decoded combinationally from the state.
REQ-019 In IDLE, DONE or ERR, start=1 SHALL clear word_count, done and error, and go to HDR0.
REQ-020 start SHALL be ignored in HDR0, HDR1, DATA and WRITE.
REQ-021 HDR0 SHALL capture the accepted byte as length[15:8] and go to HDR1.
REQ-022 HDR1 SHALL capture the accepted byte as length[7:0], then:
- go to DONE if length==0;
- go to ERR if length>MAX_WORDS;
- go to DATA otherwise.
REQ-023 DATA SHALL assemble bytes big-endian, with the first byte going to bits [31:24], using a 2-bit byte index.
REQ-024 On acceptance of the 4th byte, the next state SHALL be WRITE and the byte index SHALL wrap to 0.
REQ-025 In WRITE, for exactly one cycle:
- mem_we SHALL be 1;
- mem_wdata SHALL be the assembled word;
- mem_addr SHALL be BASE_ADDR + 4*word_count.
REQ-026 Write latency SHALL be exactly one cycle after the 4th byte handshake.
REQ-027 At the end of WRITE, word_count SHALL increment; the next state SHALL be DONE if the new count equals length, and DATA otherwise.
REQ-028 mem_we SHALL be 0 in every state other than WRITE.
REQ-029 mem_addr and mem_wdata SHALL hold their last values outside WRITE.
REQ-030 Address arithmetic SHALL be 32-bit and wrap modulo 2^32.
REQ-031 cpu_hold SHALL be 0 only in DONE.
REQ-032 done SHALL be 1 only in DONE.
REQ-033 error SHALL be 1 only in ERR.
REQ-034 A stalled source (byte_valid=0) SHALL leave all state unchanged, with no timeout.
REQ-035 A byte offered while byte_ready=0 SHALL NOT be consumed.

Reset
REQ-036 rst_n=0 SHALL immediately, without waiting for clk, force the following regardless of the current state, including mid-load:
- state IDLE;
- cpu_hold=1;
- byte_ready=0, mem_we=0, done=0, error=0;
- word_count=0, mem_addr=0, mem_wdata=0;
- byte index and length cleared to 0.
REQ-037 After rst_n is released, the loader SHALL remain in IDLE until start is asserted.

Verification
REQ-038 Normal load: start, then bytes 00 02 20 08 00 05 AC 08 00 04 -> required response:
- mem_we pulse with addr 0x0, data 0x20080005;
- mem_we pulse with addr 0x4, data 0xAC080004;
- word_count=2, done=1, cpu_hold=0.
REQ-039 Zero length: start, then bytes 00 00 -> DONE in the cycle after the 2nd byte, no mem_we, word_count=0.
REQ-040 Oversize: start, then bytes 00 41 with MAX_WORDS=64 -> error=1, cpu_hold=1, no mem_we; a following start with length 00 01 and one word loads normally.
REQ-041 Backpressure and gaps: byte_valid held high through WRITE, and random valid gaps inside a word -> no byte lost or duplicated, and every mem_wdata matches the sent words.
REQ-042 Mid-load reset: rst_n=0 after the 2nd data byte -> all outputs at reset values at once; a new load from start writes from BASE_ADDR with no leftover partial bytes.
REQ-043 Start during load: start pulsed in DATA -> ignored, and the load completes with the correct word_count.

Source files
------------

// File: rtl/imem_loader.sv
// Serial program loader: takes a 16-bit big-endian word count and then the words
// byte by byte, writing each assembled word into instruction memory while the CPU is held.
module imem_loader #(
    parameter int          MAX_WORDS = 64,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        done,
    output logic        error,
    output logic [15:0] word_count
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HDR0  = 3'd1,
        HDR1  = 3'd2,
        DATA  = 3'd3,
        WRITE = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    localparam logic [16:0] MAX_LEN = 17'(MAX_WORDS);

    state_t      state;
    state_t      state_next;
    logic [15:0] length;
    logic [1:0]  byte_idx;
    logic [31:0] word_buf;
    logic        accept;
    logic [15:0] hdr_length;
    logic [15:0] count_inc;

    assign accept     = byte_valid && byte_ready;
    assign hdr_length = {length[15:8], byte_in};
    assign count_inc  = word_count + 16'd1;

    // Status outputs are pure decodes of the state, so reset forces them without a clock.
    assign byte_ready = (state == HDR0) || (state == HDR1) || (state == DATA);
    assign mem_we     = (state == WRITE);
    assign cpu_hold   = (state != DONE);
    assign done       = (state == DONE);
    assign error      = (state == ERR);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: state_next gets its default before the case so no path can infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE, DONE, ERR: if (start) state_next = HDR0;
            HDR0:            if (accept) state_next = HDR1;
            HDR1: begin
                if (accept) begin
                    if (hdr_length == 16'd0)              state_next = DONE;
                    else if ({1'b0, hdr_length} > MAX_LEN) state_next = ERR;
                    else                                   state_next = DATA;
                end
            end
            DATA:            if (accept && byte_idx == 2'd3) state_next = WRITE;
            WRITE:           state_next = (count_inc == length) ? DONE : DATA;
            default:         state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            length     <= '0;
            byte_idx   <= '0;
            word_buf   <= '0;
            word_count <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            unique case (state)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        word_count <= '0;
                        byte_idx   <= '0;
                        length     <= '0;
                    end
                end
                HDR0: if (accept) length[15:8] <= byte_in;
                HDR1: if (accept) length[7:0]  <= byte_in;
                DATA: begin
                    if (accept) begin
                        unique case (byte_idx)
                            2'd0: word_buf[31:24] <= byte_in;
                            2'd1: word_buf[23:16] <= byte_in;
                            2'd2: word_buf[15:8]  <= byte_in;
                            2'd3: word_buf[7:0]   <= byte_in;
                            default: ;
                        endcase
                        byte_idx <= byte_idx + 2'd1;
                        // Address and data are latched on the last byte so they stay stable outside WRITE.
                        if (byte_idx == 2'd3) begin
                            mem_wdata <= {word_buf[31:8], byte_in};
                            mem_addr  <= BASE_ADDR + {14'd0, word_count, 2'b00};
                        end
                    end
                end
                WRITE: word_count <= count_inc;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected memory writes are queued by the stimulus
// and a negedge monitor pops and compares them whenever mem_we is seen.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [15:0] word_count;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_tests = 0;
    int  n_fails = 0;

    imem_loader #(.MAX_WORDS(64), .BASE_ADDR(32'h0000_0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_ready (byte_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fails++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("write_addr", mem_addr, mon_e.addr);
                check("write_data", mem_wdata, mon_e.data);
            end
        end
    end

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        byte_in    = b;
        byte_valid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (byte_ready) ok = 1'b1;
            @(negedge clk);
        end
        if (!ok) begin
            n_tests++;
            n_fails++;
            $display("FAIL byte_accept: byte 0x%0h not accepted, expected acceptance within 20 cycles", b);
        end
    endtask

    task automatic send_byte_gap(input logic [7:0] b, input int gap);
        byte_valid = 1'b0;
        byte_in    = 8'hxx;
        repeat (gap) @(negedge clk);
        send_byte(b);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic expect_write(input logic [31:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic wait_finish();
        bit ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (done || error) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            n_tests++;
            n_fails++;
            $display("FAIL load_finish: done/error still 0, expected completion within 20 cycles");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_byte_ready", 32'(byte_ready), 32'd0);
        check("rst_cpu_hold",   32'(cpu_hold),   32'd1);
        check("rst_done",       32'(done),       32'd0);
        check("rst_word_count", 32'(word_count), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_hold",  32'(cpu_hold),   32'd1);
        check("idle_ready", 32'(byte_ready), 32'd0);

        // Normal two-word load.
        pulse_start();
        expect_write(32'h0, 32'h2008_0005);
        expect_write(32'h4, 32'hAC08_0004);
        send_byte(8'h00); send_byte(8'h02);
        send_byte(8'h20); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
        check("write_latency", 32'(mem_we), 32'd1);
        send_byte(8'hAC); send_byte(8'h08); send_byte(8'h00); send_byte(8'h04);
        byte_valid = 1'b0;
        wait_finish();
        check("norm_word_count", 32'(word_count), 32'd2);
        check("norm_done",       32'(done),       32'd1);
        check("norm_cpu_hold",   32'(cpu_hold),   32'd0);
        check("norm_error",      32'(error),      32'd0);
        check("hold_addr",       mem_addr,        32'h4);
        check("hold_wdata",      mem_wdata,       32'hAC08_0004);

        // Zero length: DONE straight after the second header byte.
        pulse_start();
        check("restart_clears_done", 32'(done), 32'd0);
        send_byte(8'h00); send_byte(8'h00);
        byte_valid = 1'b0;
        check("zero_done",       32'(done),       32'd1);
        check("zero_word_count", 32'(word_count), 32'd0);

        // Oversize length, then a recovery load.
        pulse_start();
        send_byte(8'h00); send_byte(8'h41);
        byte_valid = 1'b0;
        check("over_error",    32'(error),      32'd1);
        check("over_cpu_hold", 32'(cpu_hold),   32'd1);
        check("over_done",     32'(done),       32'd0);
        check("over_ready",    32'(byte_ready), 32'd0);
        repeat (2) @(negedge clk);
        pulse_start();
        check("restart_clears_error", 32'(error), 32'd0);
        expect_write(32'h0, 32'h1234_5678);
        send_byte(8'h00); send_byte(8'h01);
        send_word(32'h1234_5678);
        byte_valid = 1'b0;
        wait_finish();
        check("recov_word_count", 32'(word_count), 32'd1);
        check("recov_done",       32'(done),       32'd1);

        // Length exactly MAX_WORDS is accepted; then reset mid-load.
        pulse_start();
        send_byte(8'h00); send_byte(8'h40);
        check("max_len_error", 32'(error),      32'd0);
        check("max_len_ready", 32'(byte_ready), 32'd1);
        expect_write(32'h0, 32'hCAFE_F00D);
        send_word(32'hCAFE_F00D);
        send_byte(8'hAA); send_byte(8'hBB);
        byte_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready",      32'(byte_ready), 32'd0);
        check("mid_rst_cpu_hold",   32'(cpu_hold),   32'd1);
        check("mid_rst_mem_we",     32'(mem_we),     32'd0);
        check("mid_rst_word_count", 32'(word_count), 32'd0);
        check("mid_rst_addr",       mem_addr,        32'h0);
        check("mid_rst_wdata",      mem_wdata,       32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        expect_write(32'h0, 32'h1122_3344);
        send_byte(8'h00); send_byte(8'h01);
        send_word(32'h1122_3344);
        byte_valid = 1'b0;
        wait_finish();
        check("post_rst_word_count", 32'(word_count), 32'd1);

        // Valid gaps inside words, valid held high across WRITE.
        pulse_start();
        expect_write(32'h0, 32'h0102_0304);
        expect_write(32'h4, 32'hA5B6_C7D8);
        expect_write(32'h8, 32'hFFEE_0011);
        send_byte(8'h00); send_byte(8'h03);
        begin
            logic [31:0] words [3];
            words[0] = 32'h0102_0304;
            words[1] = 32'hA5B6_C7D8;
            words[2] = 32'hFFEE_0011;
            for (int w = 0; w < 3; w++)
                for (int k = 3; k >= 0; k--)
                    send_byte_gap(words[w][8*k +: 8], (w * 4 + k) % 3);
        end
        byte_valid = 1'b0;
        wait_finish();
        check("gap_word_count", 32'(word_count), 32'd3);
        check("gap_done",       32'(done),       32'd1);

        // Start pulsed during DATA is ignored.
        pulse_start();
        expect_write(32'h0, 32'h0BAD_BEEF);
        expect_write(32'h4, 32'hDEAD_BEEF);
        send_byte(8'h00); send_byte(8'h02);
        send_word(32'h0BAD_BEEF);
        send_byte(8'hDE); send_byte(8'hAD);
        byte_valid = 1'b0;
        pulse_start();
        check("start_ignored_count", 32'(word_count), 32'd1);
        send_byte(8'hBE); send_byte(8'hEF);
        byte_valid = 1'b0;
        wait_finish();
        check("start_ign_word_count", 32'(word_count), 32'd2);
        check("start_ign_done",       32'(done),       32'd1);

        repeat (3) @(negedge clk);
        check("pending_writes", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
        $finish;
    end

endmodule
